// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// requester indices and the watchdog counter width.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// ram_arbiter_rr_pick
// Combinational round-robin choice between two requesters.
// Ports:
//   active      - bit i set when requester i wants the RAM
//   last_grant  - requester granted most recently
//   grant_valid - at least one requester is active
//   grant       - chosen requester (meaningful only when grant_valid)
module ram_arbiter_rr_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] active,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    always_comb begin
        grant_valid = |active;
        grant       = REQ0;
        case (active)
            2'b01:   grant = REQ0;
            2'b10:   grant = REQ1;
            // Tie: the requester that was not served last goes next.
            2'b11:   grant = ~last_grant;
            default: grant = REQ0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one RAM between two requesters with round-robin arbitration.
// One transaction at a time: IDLE picks a requester and registers its
// operation, address and write data; BUSY drives the RAM until ram_done or
// the watchdog expires; RESP pulses done or error to the owner for a cycle.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_read/req_write [1:0]   - per-requester level requests
//   req_address, req_wdata     - requester i at slice [i*W +: W]
//   req_rdata                  - data of the last completed read
//   req_done, req_error [1:0]  - one-cycle completion / timeout pulses
//   ram_en_read, ram_en_write  - RAM enables, high only in BUSY
//   ram_address, ram_wdata     - registered transaction address / data
//   ram_rdata, ram_done        - RAM read data and completion pulse
// timeout_cycles must lie in 1..255 (8-bit watchdog).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int address_width  = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_read,
    input  logic [1:0]                 req_write,
    input  logic [2*address_width-1:0] req_address,
    input  logic [2*data_width-1:0]    req_wdata,
    output logic [data_width-1:0]      req_rdata,
    output logic [1:0]                 req_done,
    output logic [1:0]                 req_error,
    output logic                       ram_en_read,
    output logic                       ram_en_write,
    output logic [address_width-1:0]   ram_address,
    output logic [data_width-1:0]      ram_wdata,
    input  logic [data_width-1:0]      ram_rdata,
    input  logic                       ram_done
);

    localparam logic [WDOG_W-1:0] TIMEOUT_LAST = WDOG_W'(timeout_cycles - 1);

    state_t                     state_q, state_d;
    logic                       grant_q, last_grant_q, op_q, err_q;
    logic [address_width-1:0]   addr_q;
    logic [data_width-1:0]      wdata_q, rdata_q;
    logic [WDOG_W-1:0]          wdog_q;

    logic [1:0] active;
    logic       grant_valid, grant;
    logic       load, done_hit, timeout_hit;

    assign active = req_read | req_write;

    ram_arbiter_rr_pick u_pick (
        .active      (active),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Next state and per-cycle strobes. ram_done beats a same-cycle timeout.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ram_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (wdog_q == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= REQ0;
            last_grant_q <= REQ1;
            op_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wdog_q       <= '0;
        end else begin
            if (load) begin
                grant_q      <= grant;
                last_grant_q <= grant;
                // Write wins when both read and write are raised.
                op_q         <= req_write[grant];
                addr_q       <= grant ? req_address[address_width +: address_width]
                                      : req_address[0 +: address_width];
                wdata_q      <= grant ? req_wdata[data_width +: data_width]
                                      : req_wdata[0 +: data_width];
                wdog_q       <= '0;
            end else if (state_q == BUSY && !done_hit && !timeout_hit &&
                         wdog_q != '1) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (done_hit) begin
                err_q <= 1'b0;
                if (!op_q) begin
                    rdata_q <= ram_rdata;
                end
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ram_en_write = (state_q == BUSY) &&  op_q;
    assign ram_en_read  = (state_q == BUSY) && !op_q;
    assign ram_address  = addr_q;
    assign ram_wdata    = wdata_q;
    assign req_rdata    = rdata_q;
    assign req_done     = (state_q == RESP && !err_q) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign req_error    = (state_q == RESP &&  err_q) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter (timeout_cycles = 4). A behavioural RAM
// answers after a programmable number of enable cycles; expected responses
// {req_done, req_error, req_rdata} are queued by the stimulus and popped by a
// monitor whenever the arbiter pulses done or error.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_read, req_write;
    logic [2*AW-1:0] req_address;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_done, req_error;
    logic            ram_en_read, ram_en_write;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            ram_done;

    ram_arbiter #(
        .address_width  (AW),
        .data_width     (DW),
        .timeout_cycles (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .req_rdata    (req_rdata),
        .req_done     (req_done),
        .req_error    (req_error),
        .ram_en_read  (ram_en_read),
        .ram_en_write (ram_en_write),
        .ram_address  (ram_address),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_done     (ram_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2+2+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (req_done != 2'b00 || req_error != 2'b00)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%b error=%b, expected no pulse",
                         req_done, req_error);
            end else begin
                check("response", {req_done, req_error, req_rdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- RAM model ----------------
    int            ram_lat    = -1;   // enable cycles before done; -1 never answers
    bit            stray_done = 1'b0;
    logic [DW-1:0] ram_ret    = '0;
    int            en_cnt     = 0;
    int            en_len     = 0;
    logic [AW-1:0] cap_addr   = '0;
    logic [DW-1:0] cap_wdata  = '0;
    bit            cap_wr     = 1'b0;
    bit            unstable   = 1'b0;

    assign ram_rdata = ram_ret;

    initial ram_done = 1'b0;

    always @(negedge clk) begin
        if (ram_en_read || ram_en_write) begin
            en_cnt = en_cnt + 1;
            if (en_cnt == 1) begin
                cap_addr  = ram_address;
                cap_wdata = ram_wdata;
                cap_wr    = ram_en_write;
            end else if (ram_address != cap_addr || ram_wdata != cap_wdata) begin
                unstable = 1'b1;
            end
            ram_done = (ram_lat >= 0 && en_cnt == ram_lat + 1);
        end else begin
            if (en_cnt != 0) en_len = en_cnt;
            en_cnt   = 0;
            ram_done = stray_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input int r, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int lat);
        bit got = 1'b0;
        ram_lat = lat;
        unstable = 1'b0;
        @(posedge clk); #1;
        req_address[r*AW +: AW] = addr;
        req_wdata[r*DW +: DW]   = wdata;
        if (wr) req_write[r] = 1'b1; else req_read[r] = 1'b1;
        // Arbiter is in BUSY now; input changes must not reach the RAM.
        @(posedge clk); #1;
        req_address[r*AW +: AW] = ~addr;
        req_wdata[r*DW +: DW]   = ~wdata;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (req_done[r] || req_error[r]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("txn_wait", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_read[r]  = 1'b0;
        req_write[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdata"},  req_rdata,    0);
        check({tag, "_done"},   req_done,     0);
        check({tag, "_error"},  req_error,    0);
        check({tag, "_en_rd"},  ram_en_read,  0);
        check({tag, "_en_wr"},  ram_en_write, 0);
        check({tag, "_addr"},   ram_address,  0);
        check({tag, "_wdata"},  ram_wdata,    0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        reset       = 1'b1;
        req_read    = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Both requesters continuously active: grants 0,1,0,1.
        ram_lat = 0;
        exp_q.push_back({2'b01, 2'b00, 32'h0});
        exp_q.push_back({2'b10, 2'b00, 32'h0});
        exp_q.push_back({2'b01, 2'b00, 32'h0});
        exp_q.push_back({2'b10, 2'b00, 32'h0});
        req_address = {32'h200, 32'h100};
        req_wdata   = {32'h2222, 32'h1111};
        req_write   = 2'b11;
        seen = 0;
        for (int c = 0; c < 100 && seen < 4; c++) begin
            @(negedge clk);
            if (req_done != 2'b00 || req_error != 2'b00) seen++;
        end
        check("rr_pulses", seen, 4);
        @(posedge clk); #1;
        req_write = 2'b00;
        repeat (2) @(negedge clk);

        // Requester 0 writes 0xDEADBEEF to 0x10, RAM answers after 2 cycles.
        exp_q.push_back({2'b01, 2'b00, 32'h0});
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2);
        check("wr_en_len",   en_len,    3);
        check("wr_addr",     cap_addr,  32'h10);
        check("wr_wdata",    cap_wdata, 32'hDEADBEEF);
        check("wr_is_write", cap_wr,    1);
        check("wr_stable",   unstable,  0);

        // Requester 1 reads 0x20, RAM returns 0x12345678.
        ram_ret = 32'h12345678;
        exp_q.push_back({2'b10, 2'b00, 32'h12345678});
        run_txn(1, 1'b0, 32'h20, 32'h0, 1);
        check("rd_en_len",  en_len,    2);
        check("rd_addr",    cap_addr,  32'h20);
        check("rd_is_read", cap_wr,    0);
        check("rd_hold",    req_rdata, 32'h12345678);

        // A following write must leave req_rdata unchanged.
        ram_ret = 32'hBAD0BAD0;
        exp_q.push_back({2'b01, 2'b00, 32'h12345678});
        run_txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 0);
        check("wr2_wdata",  cap_wdata, 32'hCAFEF00D);
        check("wr2_rdata",  req_rdata, 32'h12345678);

        // RAM never answers: 4 enable cycles, error to requester 1.
        exp_q.push_back({2'b00, 2'b10, 32'h12345678});
        run_txn(1, 1'b0, 32'h40, 32'h0, -1);
        check("to_en_len",  en_len,    4);
        check("to_rdata",   req_rdata, 32'h12345678);

        // Reset in BUSY: outputs drop at once, no pulse follows.
        ram_lat = -1;
        @(posedge clk); #1;
        req_address[0 +: AW] = 32'h50;
        req_read[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_busy_en", ram_en_read, 1);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        req_read = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_rdata", req_rdata, 0);

        // Tie after reset: requester 0 wins.
        ram_lat = 0;
        exp_q.push_back({2'b01, 2'b00, 32'h0});
        @(posedge clk); #1;
        req_write = 2'b11;
        seen = 0;
        for (int c = 0; c < 50 && seen < 1; c++) begin
            @(negedge clk);
            if (req_done != 2'b00 || req_error != 2'b00) seen++;
        end
        check("tie_pulse", seen, 1);
        @(posedge clk); #1;
        req_write = 2'b00;
        repeat (2) @(negedge clk);

        // Stray ram_done while idle produces nothing.
        @(posedge clk); #1;
        stray_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stray_done",  req_done,  0);
            check("stray_error", req_error, 0);
            check("stray_en",    {ram_en_read, ram_en_write}, 0);
        end
        stray_done = 1'b0;
        repeat (3) @(negedge clk);

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
